// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: accepts one core request, validates it, issues a
// single-cycle memory access and returns a registered response.
module lsu_mem_ctrl #(
  parameter int MEM_WORDS = 32,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_store_i,
  input  logic                  req_vector_i,
  input  logic [31:0]           req_addr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_zero_extnd_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [3:0][127:0]     req_vwdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic                  resp_err_o,
  output logic [31:0]           resp_rdata_o,
  output logic [3:0][127:0]     resp_vrdata_o,
  output logic                  data_req_o,
  output logic                  data_wr_o,
  output logic [31:0]           data_addr_o,
  output logic [1:0]            data_byte_en_o,
  output logic                  data_zero_extnd_o,
  output logic                  is_vector_o,
  output logic [31:0]           data_wr_data_o,
  output logic [3:0][127:0]     vec_data_wr_data_o,
  input  logic [31:0]           data_mem_rd_data_i,
  input  logic [3:0][127:0]     vec_mem_rd_data_i,
  output logic [CNT_W-1:0]      load_cnt_o,
  output logic [CNT_W-1:0]      store_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  localparam logic [31:0]      LAST_LINE = 32'(MEM_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e               state_q, state_d;
  logic                 store_q, store_d;
  logic                 vector_q, vector_d;
  logic                 zext_q, zext_d;
  logic                 err_q, err_d;
  logic [31:0]          addr_q, addr_d;
  logic [1:0]           size_q, size_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0][127:0]    vwdata_q, vwdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [3:0][127:0]    vrdata_q, vrdata_d;
  logic [CNT_W-1:0]     load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]     store_cnt_q, store_cnt_d;

  // A vector touches four consecutive lines, so the last one must still exist.
  function automatic logic req_error(input logic vec, input logic [31:0] addr,
                                     input logic [1:0] size);
    logic bad;
    bad = 1'b0;
    if (vec) begin
      bad = (addr[3:0] != 4'h0) || (({4'h0, addr[31:4]} + 32'd3) > LAST_LINE);
    end else begin
      case (size)
        2'b00:   bad = 1'b0;
        2'b01:   bad = addr[0];
        default: bad = (addr[1:0] != 2'b00);
      endcase
    end
    return bad;
  endfunction

  // Next-state, request latching, read capture and counter update.
  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    vector_d    = vector_q;
    zext_d      = zext_q;
    err_d       = err_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    vwdata_d    = vwdata_q;
    rdata_d     = rdata_q;
    vrdata_d    = vrdata_q;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          store_d  = req_store_i;
          vector_d = req_vector_i;
          zext_d   = req_zero_extnd_i;
          addr_d   = req_addr_i;
          // The reserved size code behaves exactly like a word access.
          size_d   = (req_size_i == 2'b10) ? 2'b11 : req_size_i;
          wdata_d  = req_wdata_i;
          vwdata_d = req_vwdata_i;
          rdata_d  = 32'h0;
          vrdata_d = '0;
          err_d    = req_error(req_vector_i, req_addr_i, req_size_i);
          state_d  = err_d ? RESP : ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!store_q) begin
          if (vector_q) begin
            vrdata_d = vec_mem_rd_data_i;
          end else begin
            rdata_d = data_mem_rd_data_i;
          end
        end else begin
          rdata_d = rdata_q;
        end
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
          if (err_q) begin
            load_cnt_d = load_cnt_q;
          end else if (store_q) begin
            store_cnt_d = (store_cnt_q == CNT_MAX) ? store_cnt_q : store_cnt_q + 1'b1;
          end else begin
            load_cnt_d = (load_cnt_q == CNT_MAX) ? load_cnt_q : load_cnt_q + 1'b1;
          end
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      vector_q    <= 1'b0;
      zext_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= 32'h0;
      size_q      <= 2'b00;
      wdata_q     <= 32'h0;
      vwdata_q    <= '0;
      rdata_q     <= 32'h0;
      vrdata_q    <= '0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      vector_q    <= vector_d;
      zext_q      <= zext_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      vwdata_q    <= vwdata_d;
      rdata_q     <= rdata_d;
      vrdata_q    <= vrdata_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign req_ready_o        = (state_q == IDLE);
  assign resp_valid_o       = (state_q == RESP);
  assign resp_err_o         = err_q;
  assign resp_rdata_o       = rdata_q;
  assign resp_vrdata_o      = vrdata_q;
  assign data_req_o         = (state_q == ACCESS);
  assign data_wr_o          = (state_q == ACCESS) & store_q;
  assign data_addr_o        = addr_q;
  assign data_byte_en_o     = size_q;
  assign data_zero_extnd_o  = zext_q;
  assign is_vector_o        = vector_q;
  assign data_wr_data_o     = wdata_q;
  assign vec_data_wr_data_o = vwdata_q;
  assign load_cnt_o         = load_cnt_q;
  assign store_cnt_o        = store_cnt_q;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator that sits between the core's execute stage and the scalar/vector data memory.
- Accepts one request at a time from the core over a valid/ready handshake.
- Checks alignment and range, then drives the memory request bus (req, wr, addr, size, zero-extend, vector flag, vector write data) for exactly one cycle.
- Captures the memory's combinational read data and returns a registered response over a valid/ready handshake.

Parameters:
- MEM_WORDS, 32, depth of data memory in 128-bit lines; used for vector range checking.
- CNT_W, 16, width of the saturating load/store statistics counters.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  LSU can accept a request (high only in IDLE)
- req_store_i  in  1  1=store, 0=load
- req_vector_i  in  1  1=vector (4x128-bit) access
- req_addr_i  in  32  byte address
- req_size_i  in  2  BYTE=2'b00, HALF_WORD=2'b01, WORD=2'b11 (yarp_pkg encoding); ignored for vector
- req_zero_extnd_i  in  1  zero-extend scalar load
- req_wdata_i  in  32  scalar store data
- req_vwdata_i  in  128x4  vector store data
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  core accepts response
- resp_err_o  out  1  request rejected (misaligned or out of range)
- resp_rdata_o  out  32  scalar load data; 0 for stores/errors
- resp_vrdata_o  out  128x4  vector load data; 0 for stores/errors
- data_req_o  out  1  memory request strobe
- data_wr_o  out  1  memory write enable
- data_addr_o  out  32  memory address
- data_byte_en_o  out  2  memory access size
- data_zero_extnd_o  out  1  memory zero-extend
- is_vector_o  out  1  memory vector access
- data_wr_data_o  out  32  memory scalar write data
- vec_data_wr_data_o  out  128x4  memory vector write data
- data_mem_rd_data_i  in  32  memory scalar read data (combinational)
- vec_mem_rd_data_i  in  128x4  memory vector read data (combinational)
- load_cnt_o  out  CNT_W  completed loads, saturating
- store_cnt_o  out  CNT_W  completed stores, saturating

Behaviour:
- Reset (async, immediate): state=IDLE; every output listed above is 0, except req_ready_o=1 (it is derived from state).
- States:
  - IDLE: req_ready_o=1. On req_valid_i & req_ready_o, latch all request fields.
    - If the error check fails: go to RESP with err=1, and no memory cycle is issued.
    - Otherwise: go to ACCESS.
  - ACCESS (exactly 1 cycle): data_req_o=1, all memory outputs driven from latched registers, data_wr_o=latched store bit.
    - Loads: capture data_mem_rd_data_i (scalar) or vec_mem_rd_data_i (vector) at the end of this cycle.
    - Stores: the memory commits on this same clock edge.
    - Next state: RESP.
  - RESP: resp_valid_o=1, fields stable until resp_ready_i. On resp_valid_o & resp_ready_i, go to IDLE.
- Error conditions:
  - HALF_WORD with addr[0]=1.
  - WORD with addr[1:0]!=0.
  - Vector with addr[3:0]!=0.
  - Vector with addr[31:4]+3 > MEM_WORDS-1.
  - req_size_i=2'b10 is treated as WORD.
- Memory bus outside ACCESS: data_req_o=0 and data_wr_o=0. Other data_* outputs hold their last value; they are don't-care to the memory.
- Latency:
  - Handshake at edge T: data_req_o is high in cycle T+1, and resp_valid_o is high from T+2.
  - Error: resp_valid_o is high from T+1.
  - Minimum issue interval is 3 cycles (2 for errors). No back-to-back acceptance: req_ready_o is low in ACCESS and RESP.
- Response data:
  - Scalar load: resp_rdata_o=captured value; resp_vrdata_o=0.
  - Vector load: the reverse.
  - Stores and errors: both data outputs 0.
- Counters: incremented on the response handshake of a non-error load/store. They saturate at all-ones with no wrap. Errors are not counted.
- Response stall: holding resp_ready_i low keeps RESP and all response outputs stable indefinitely. No new request is accepted during the stall.
- Reset mid-operation: reset asserted during ACCESS drops data_req_o and data_wr_o to 0 asynchronously. Whether a store commits on that edge is not guaranteed. State returns to IDLE and counters clear.

Test Plan:
- Scalar word store then load:
  - Store addr 0x24, data 0xDEADBEEF, size WORD.
  - Required: data_req_o and data_wr_o high exactly one cycle at T+1; resp_valid_o at T+2; store_cnt_o=1.
  - Follow-up load of addr 0x24 returns resp_rdata_o=0xDEADBEEF; load_cnt_o=1.
- Byte load sign/zero-extension:
  - Store 0x00000080 at addr 0x10 (size BYTE).
  - Load BYTE addr 0x10 with zero_extnd=0 -> resp_rdata_o=0xFFFFFF80.
  - Same load with zero_extnd=1 -> resp_rdata_o=0x00000080.
- Vector round trip:
  - Vector store at addr 0x40 with lanes 0x1111..., 0x2222..., 0x3333..., 0x4444....
  - Vector load at addr 0x40 -> resp_vrdata_o matches lane for lane; is_vector_o=1 during ACCESS.
- Error checks:
  - WORD load at 0x22 -> resp_err_o=1 at T+1, data_req_o never asserted, counters unchanged.
  - Vector store at 0x1D0 (line 29, 29+3>31) -> same response.
- Response backpressure:
  - Hold resp_ready_i=0 for 5 cycles after a load.
  - Required: resp_valid_o and resp_rdata_o stable; req_ready_o=0; a second req_valid_i is not accepted until the cycle after the handshake.
- Reset mid-operation:
  - Assert reset during ACCESS of a store.
  - Required: data_req_o and data_wr_o are 0 immediately; after release req_ready_o=1 and counters=0.
